toggle_hs_rx: RTL and testbench
===============================

Name: toggle_hs_rx

Overview:
Receiving end of the team's two-phase toggle handshake. A sender signals each new word by toggling req_tgl, the same way a T flip-flop toggles on t=1. This block synchronises the toggle, detects that a transfer is pending, and captures req_data into a small FIFO. It acknowledges each capture by toggling ack_tgl and presents the stored words downstream with a valid/ready interface.

Parameters:
DATA_W, 8, width of transferred word
DEPTH, 4, FIFO entries; power of two, >=2
SYNC_STAGES, 2, flops in req_tgl synchroniser; >=1

Ports:
clk  in  1  single clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
req_tgl  in  1  sender request toggle; a level change means new word
req_data  in  DATA_W  sender data; held stable by sender until ack_tgl matches req_tgl
ack_tgl  out  1  acknowledge toggle; flips once per captured word
out_data  out  DATA_W  head-of-FIFO word; 0 when out_valid=0
out_valid  out  1  FIFO non-empty
out_ready  in  1  downstream accepts head word
count  out  $clog2(DEPTH)+1  current FIFO occupancy
proto_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset: applies on the posedge where rst=1. It clears the sync chain, req_prev, ack_tgl, wr/rd pointers, count and proto_err. After reset, out_valid=0, out_data=0, count=0, ack_tgl=0.
- Sender and this block share the same reset. Sender req_tgl resets to 0.
- Reset mid-operation discards all buffered words and any pending request.
- Sync: req_s[0]<=req_tgl, req_s[i]<=req_s[i-1]. req_sync=req_s[SYNC_STAGES-1]. req_prev<=req_sync every cycle.
- pending = (req_sync != ack_tgl).
- State (derived): IDLE when !pending. WAIT when pending & full & !pop. CAPTURE when pending & (!full | pop).
- pop = out_valid & out_ready.
- push = pending & (count<DEPTH | pop):
  - On push: mem[wr_ptr]<=req_data, wr_ptr++ (wraps mod DEPTH), ack_tgl<=~ack_tgl.
  - At most one push per cycle.
- Latency: if req_tgl changes before posedge n, req_s[0] takes it at n. Push and ack_tgl flip occur at posedge n+SYNC_STAGES. The word is visible on out_data/out_valid in the same cycle ack_tgl flips.
- FIFO is first-word-fallthrough:
  - out_data = mem[rd_ptr] gated to 0 when empty.
  - out_valid = (count!=0), registered via count.
  - On pop, rd_ptr++ (wraps).
- count update: +1 on push only; -1 on pop only; unchanged on both or neither.
- Empty + pending + out_ready: push only. No pop that cycle because out_valid was 0.
- Full + pending + pop in the same cycle: push and pop both occur, count stays DEPTH, ack flips.
- Full without pop: stay in WAIT. req_data is not sampled and ack_tgl holds, so backpressure propagates to the sender.
- Protocol error: req_sync != req_prev while req_prev != ack_tgl means a second toggle arrived before the ack.
  - proto_err<=1, sticky until rst.
  - pending then reads 0 and the in-flight word is dropped, not pushed.
- ack_tgl never flips except on push.

Test Plan:
1. Reset: hold rst=1 two cycles with arbitrary inputs -> ack_tgl=0, out_valid=0, out_data=0, count=0, proto_err=0.
2. Single transfer (SYNC_STAGES=2), out_ready=0:
   - Stimulus: req_data=8'hA5, req_tgl 0->1 before posedge n.
   - At posedge n+2: ack_tgl=1, out_valid=1, out_data=A5, count=1.
   - Then set out_ready=1 -> next posedge count=0, out_valid=0, out_data=0.
3. Full and stall (DEPTH=4), out_ready=0:
   - Send words 01..05, each waiting for ack before toggling again.
   - After 4 acks: count=4, and the 5th request pends with ack_tgl unchanged for 10 cycles.
   - Pulse out_ready one cycle -> on that edge 01 is popped, 05 is pushed, count stays 4, ack_tgl flips.
4. Ordering/wrap: then hold out_ready=1 -> out_data sequence 02,03,04,05 on consecutive cycles, then out_valid=0, count=0. Pointers have wrapped; a further word 06 is received correctly.
5. Protocol error: with FIFO full, toggle req_tgl twice, 3 cycles apart, without ack -> proto_err=1 and stays 1. count is unchanged and ack_tgl is unchanged. proto_err clears only after rst.
6. Reset mid-operation: count=3 and a request pending, then assert rst one cycle -> count=0, out_valid=0, ack_tgl=0, and no push after release with req_tgl=0.

Source files
------------

// File: rtl/toggle_hs_rx.sv
// rtl/toggle_hs_rx.sv - receiving end of the two-phase toggle handshake
// Synchronises req_tgl, captures one word per pending toggle into a FWFT FIFO, acks by toggling ack_tgl.
module toggle_hs_rx #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_tgl,
  input  logic [DATA_W-1:0]        req_data,
  output logic                     ack_tgl,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CAPTURE
  } state_e;

  logic [SYNC_STAGES-1:0] req_s_q, req_s_d;
  logic                   req_prev_q;
  logic                   ack_q, ack_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   err_q, err_d;
  logic [DATA_W-1:0]      mem_q [DEPTH];

  logic   req_sync;
  logic   pending;
  logic   full;
  logic   pop;
  logic   push;
  logic   err_now;
  state_e state;

  assign req_sync = req_s_q[SYNC_STAGES-1];
  assign pending  = (req_sync != ack_q);
  assign full     = (count_q == CNT_FULL);
  assign pop      = out_valid & out_ready;
  assign push     = (state == ST_CAPTURE);

  // A second edge on req_sync while the first is still unacked; req_sync then equals
  // ack_q again, so pending drops and the in-flight word is never pushed.
  assign err_now  = (req_sync != req_prev_q) && (req_prev_q != ack_q);

  always_comb begin
    state = ST_IDLE;
    if (pending) begin
      state = (full && !pop) ? ST_WAIT : ST_CAPTURE;
    end
  end

  always_comb begin
    req_s_d    = req_s_q;
    req_s_d[0] = req_tgl;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      req_s_d[i] = req_s_q[i-1];
    end
  end

  always_comb begin
    ack_d    = ack_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    err_d    = err_q | err_now;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
      ack_d    = ~ack_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_s_q    <= '0;
      req_prev_q <= 1'b0;
      ack_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      req_s_q    <= req_s_d;
      req_prev_q <= req_sync;
      ack_q      <= ack_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= req_data;
    end
  end

  assign ack_tgl   = ack_q;
  assign count     = count_q;
  assign proto_err = err_q;
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_toggle_hs_rx.sv
// tb/tb_toggle_hs_rx.sv - self-checking bench for toggle_hs_rx
// Queue-based reference model compared every cycle, plus directed literal checks.
module tb_toggle_hs_rx;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int SYNC   = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_tgl = 1'b0;
  logic [DATA_W-1:0] req_data = '0;
  logic              out_ready = 1'b0;
  logic              ack_tgl;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic [2:0]        count;
  logic              proto_err;

  int total = 0;
  int bad   = 0;

  toggle_hs_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_tgl   (req_tgl),
    .req_data  (req_data),
    .ack_tgl   (ack_tgl),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: delay line for the synchroniser, a queue for the FIFO.
  bit              h [SYNC];
  bit              m_prev;
  bit              m_ack;
  bit              m_err;
  bit              m_live = 1'b0;
  byte unsigned    mq [$];

  always @(posedge clk) begin
    bit s, pend, pop, push;
    if (rst) begin
      for (int i = 0; i < SYNC; i++) h[i] = 1'b0;
      m_prev = 1'b0;
      m_ack  = 1'b0;
      m_err  = 1'b0;
      mq.delete();
      m_live = 1'b1;
    end else begin
      s    = h[SYNC-1];
      pend = (s != m_ack);
      pop  = (mq.size() != 0) && out_ready;
      push = pend && ((mq.size() < DEPTH) || pop);
      if (s != m_prev && m_prev != m_ack) m_err = 1'b1;
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back(req_data);
        m_ack = !m_ack;
      end
      m_prev = s;
      for (int i = SYNC - 1; i > 0; i--) h[i] = h[i-1];
      h[0] = req_tgl;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("mdl_ack",   32'(ack_tgl),   32'(m_ack));
      check("mdl_valid", 32'(out_valid), 32'(mq.size() != 0));
      check("mdl_data",  32'(out_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
      check("mdl_count", 32'(count),     32'(mq.size()));
      check("mdl_err",   32'(proto_err), 32'(m_err));
    end
  end

  task automatic nxt();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] w);
    int k;
    req_data = w;
    req_tgl  = ~req_tgl;
    k = 0;
    while (ack_tgl != req_tgl && k < 20) begin
      nxt();
      k++;
    end
    check("ack_wait", 32'(k < 20), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    req_data  = 8'hFF;
    out_ready = 1'b1;
    req_tgl   = 1'b0;
    nxt();
    nxt();
    check("rst_ack",   32'(ack_tgl),   32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_count", 32'(count),     32'd0);
    check("rst_err",   32'(proto_err), 32'd0);
    rst       = 1'b0;
    out_ready = 1'b0;

    // single transfer: visible exactly SYNC_STAGES edges after req_s[0] takes the toggle
    req_data = 8'hA5;
    req_tgl  = 1'b1;
    nxt();
    check("lat_n_ack", 32'(ack_tgl), 32'd0);
    nxt();
    check("lat_n1_ack",   32'(ack_tgl),   32'd0);
    check("lat_n1_valid", 32'(out_valid), 32'd0);
    nxt();
    check("xfer_ack",   32'(ack_tgl),   32'd1);
    check("xfer_valid", 32'(out_valid), 32'd1);
    check("xfer_data",  32'(out_data),  32'hA5);
    check("xfer_count", 32'(count),     32'd1);
    out_ready = 1'b1;
    nxt();
    check("pop_count", 32'(count),     32'd0);
    check("pop_valid", 32'(out_valid), 32'd0);
    check("pop_data",  32'(out_data),  32'd0);
    out_ready = 1'b0;

    // fill, then stall the fifth word
    for (int w = 1; w <= 4; w++) send(8'(w));
    check("full_count", 32'(count), 32'd4);
    req_data = 8'h05;
    req_tgl  = ~req_tgl;
    repeat (10) nxt();
    check("stall_ack",   32'(ack_tgl),  32'd1);
    check("stall_count", 32'(count),    32'd4);
    check("stall_head",  32'(out_data), 32'h01);
    out_ready = 1'b1;
    nxt();
    check("pushpop_count", 32'(count),    32'd4);
    check("pushpop_ack",   32'(ack_tgl),  32'd0);
    check("pushpop_head",  32'(out_data), 32'h02);

    // drain in order across the pointer wrap
    for (int w = 3; w <= 5; w++) begin
      nxt();
      check("drain_data", 32'(out_data), 32'(w));
    end
    nxt();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_count", 32'(count),     32'd0);
    send(8'h06);
    check("w6_data",  32'(out_data),  32'h06);
    check("w6_valid", 32'(out_valid), 32'd1);
    check("w6_count", 32'(count),     32'd1);
    nxt();
    check("w6_drain", 32'(count), 32'd0);
    out_ready = 1'b0;

    // protocol error: double toggle while full
    for (int w = 7; w <= 10; w++) send(8'(w));
    check("pe_full", 32'(count), 32'd4);
    req_data = 8'h0B;
    req_tgl  = ~req_tgl;
    repeat (3) nxt();
    req_tgl  = ~req_tgl;
    repeat (6) nxt();
    check("pe_err",   32'(proto_err), 32'd1);
    check("pe_count", 32'(count),     32'd4);
    check("pe_ack",   32'(ack_tgl),   32'd1);
    repeat (5) nxt();
    check("pe_sticky", 32'(proto_err), 32'd1);

    // reset mid-operation with three words buffered and a request pending
    out_ready = 1'b1;
    nxt();
    out_ready = 1'b0;
    check("mid_count", 32'(count), 32'd3);
    req_data = 8'h0C;
    req_tgl  = ~req_tgl;
    nxt();
    nxt();
    check("mid_pend_count", 32'(count), 32'd3);
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    check("mrst_count", 32'(count),     32'd0);
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_ack",   32'(ack_tgl),   32'd0);
    check("mrst_err",   32'(proto_err), 32'd0);
    repeat (5) nxt();
    check("post_count", 32'(count),   32'd0);
    check("post_ack",   32'(ack_tgl), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
